// File: rtl/hpm_counter_ctrl_pkg.sv
// Shared definitions for the performance-monitor controller: CSR index
// helpers, the latched response record and the CSR handshake states.
package HPMPkg;

    localparam int CSR_DATA_W = 64;

    // Counters occupy the bottom of the CSR index space.
    localparam int CNT_BASE = 0;

    // Event selects follow the counters.
    function automatic int sel_base(input int counter_num);
        return counter_num;
    endfunction

    function automatic int inhibit_idx(input int counter_num);
        return 2 * counter_num;
    endfunction

    function automatic int ovf_idx(input int counter_num);
        return 2 * counter_num + 1;
    endfunction

    // Outcome of an accepted request, held stable while the response waits.
    typedef struct packed {
        logic                  err;
        logic [CSR_DATA_W-1:0] rdata;
    } csr_lat_t;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } csr_state_e;

endpackage

// File: rtl/hpm_counter_ctrl_counter.sv
// One programmable counter: count value, event select and sticky overflow.
module hpm_counter
    import HPMPkg::*;
#(
    parameter int COUNTER_WIDTH = 48,
    parameter int SEL_WIDTH     = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inc_i,
    input  logic                     cnt_we_i,
    input  logic [COUNTER_WIDTH-1:0] cnt_wdata_i,
    input  logic                     sel_we_i,
    input  logic [SEL_WIDTH-1:0]     sel_wdata_i,
    input  logic                     clr_ovf_i,
    output logic [COUNTER_WIDTH-1:0] count_o,
    output logic [SEL_WIDTH-1:0]     sel_o,
    output logic                     ovf_o
);

    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [SEL_WIDTH-1:0]     sel_q, sel_d;
    logic                     ovf_q, ovf_d;
    logic                     wrap;

    // Next-state: a CSR write beats a same-cycle increment; a wrap beats a clear.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        sel_d = sel_q;
        wrap  = inc_i && !cnt_we_i && (cnt_q == '1);
        if (cnt_we_i) begin
            cnt_d = cnt_wdata_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + COUNTER_WIDTH'(1);
        end
        if (sel_we_i) begin
            sel_d = sel_wdata_i;
        end
        ovf_d = wrap || (ovf_q && !clr_ovf_i);
    end

    // State registers; selects reset to all-ones so every counter starts disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            cnt_q <= '0;
            sel_q <= '1;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
            ovf_q <= ovf_d;
        end
    end

    assign count_o = cnt_q;
    assign sel_o   = sel_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/hpm_counter_ctrl.sv
// Performance-monitor controller: registers the event lines, steers them to
// the counter bank through per-counter selects, and serves a valid/ready CSR
// port with a one-request-at-a-time IDLE/RESP handshake.
module hpm_counter_ctrl
    import HPMPkg::*;
#(
    parameter int EVENT_NUM     = 32,
    parameter int COUNTER_NUM   = 8,
    parameter int COUNTER_WIDTH = 48,
    parameter int ADDR_WIDTH    = $clog2(2 * COUNTER_NUM + 2)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [EVENT_NUM-1:0]   events,
    input  logic                   csr_req_valid,
    output logic                   csr_req_ready,
    input  logic                   csr_req_we,
    input  logic [ADDR_WIDTH-1:0]  csr_req_addr,
    input  logic [CSR_DATA_W-1:0]  csr_req_wdata,
    output logic                   csr_resp_valid,
    input  logic                   csr_resp_ready,
    output logic [CSR_DATA_W-1:0]  csr_resp_rdata,
    output logic                   csr_resp_err,
    output logic [COUNTER_NUM-1:0] overflow
);

    localparam int SEL_WIDTH   = $clog2(EVENT_NUM) + 1;
    localparam int EV_IDX_W    = $clog2(EVENT_NUM);
    localparam int SEL_BASE    = sel_base(COUNTER_NUM);
    localparam int INHIBIT_IDX = inhibit_idx(COUNTER_NUM);
    localparam int OVF_IDX     = ovf_idx(COUNTER_NUM);

    logic [EVENT_NUM-1:0]     ev_q;
    logic [COUNTER_NUM-1:0]   inhibit_q, inhibit_d;
    csr_state_e               state_q, state_d;
    csr_lat_t                 resp_q, resp_d;

    logic [COUNTER_WIDTH-1:0] cnt_val [COUNTER_NUM];
    logic [SEL_WIDTH-1:0]     sel_val [COUNTER_NUM];
    logic [COUNTER_NUM-1:0]   inc, cnt_we, sel_we, ovf_clr, ovf_flags;
    logic                     wr_hs, inhibit_we, addr_hit;
    logic [CSR_DATA_W-1:0]    rd_data;
    logic                     unused_wdata;

    // Only the low bits of write data reach any register.
    assign unused_wdata = ^csr_req_wdata;

    assign wr_hs = csr_req_valid && (state_q == IDLE) && csr_req_we;

    // Event steering: out-of-range selects and inhibited counters never count.
    always_comb begin
        inc = '0;
        for (int i = 0; i < COUNTER_NUM; i++) begin
            if ((sel_val[i] < SEL_WIDTH'(EVENT_NUM)) && !inhibit_q[i]) begin
                inc[i] = ev_q[sel_val[i][EV_IDX_W-1:0]];
            end
        end
    end

    // CSR decode: write strobes plus the read sample taken before this cycle's increments.
    always_comb begin
        cnt_we     = '0;
        sel_we     = '0;
        ovf_clr    = '0;
        inhibit_we = 1'b0;
        addr_hit   = 1'b0;
        rd_data    = '0;
        inhibit_d  = inhibit_q;
        for (int i = 0; i < COUNTER_NUM; i++) begin
            if (csr_req_addr == ADDR_WIDTH'(CNT_BASE + i)) begin
                addr_hit  = 1'b1;
                rd_data   = CSR_DATA_W'(cnt_val[i]);
                cnt_we[i] = wr_hs;
            end
            if (csr_req_addr == ADDR_WIDTH'(SEL_BASE + i)) begin
                addr_hit  = 1'b1;
                rd_data   = CSR_DATA_W'(sel_val[i]);
                sel_we[i] = wr_hs;
            end
        end
        if (csr_req_addr == ADDR_WIDTH'(INHIBIT_IDX)) begin
            addr_hit   = 1'b1;
            rd_data    = CSR_DATA_W'(inhibit_q);
            inhibit_we = wr_hs;
        end
        if (csr_req_addr == ADDR_WIDTH'(OVF_IDX)) begin
            addr_hit = 1'b1;
            rd_data  = CSR_DATA_W'(ovf_flags);
            if (wr_hs) begin
                ovf_clr = csr_req_wdata[COUNTER_NUM-1:0];
            end
        end
        if (inhibit_we) begin
            inhibit_d = csr_req_wdata[COUNTER_NUM-1:0];
        end
    end

    // Handshake FSM: accept in IDLE, hold the latched response in RESP until consumed.
    always_comb begin
        state_d        = state_q;
        resp_d         = resp_q;
        csr_req_ready  = 1'b0;
        csr_resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                csr_req_ready = 1'b1;
                if (csr_req_valid) begin
                    resp_d.err   = !addr_hit;
                    resp_d.rdata = csr_req_we ? '0 : rd_data;
                    state_d      = RESP;
                end
            end
            RESP: begin
                csr_resp_valid = 1'b1;
                if (csr_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers: event sample, inhibit mask, FSM state and held response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ev_q      <= '0;
            inhibit_q <= '0;
            state_q   <= IDLE;
            resp_q    <= '0;
        end else begin
            ev_q      <= events;
            inhibit_q <= inhibit_d;
            state_q   <= state_d;
            resp_q    <= resp_d;
        end
    end

    for (genvar g = 0; g < COUNTER_NUM; g++) begin : g_cnt
        hpm_counter #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .SEL_WIDTH     (SEL_WIDTH)
        ) u_cnt (
            .clk         (clk),
            .rst_n       (rst),
            .inc_i       (inc[g]),
            .cnt_we_i    (cnt_we[g]),
            .cnt_wdata_i (csr_req_wdata[COUNTER_WIDTH-1:0]),
            .sel_we_i    (sel_we[g]),
            .sel_wdata_i (csr_req_wdata[SEL_WIDTH-1:0]),
            .clr_ovf_i   (ovf_clr[g]),
            .count_o     (cnt_val[g]),
            .sel_o       (sel_val[g]),
            .ovf_o       (ovf_flags[g])
        );
    end

    assign csr_resp_rdata = resp_q.rdata;
    assign csr_resp_err   = resp_q.err;
    assign overflow       = ovf_flags;

endmodule

// File: tb/tb_hpm_counter_ctrl.sv
// Self-checking bench for hpm_counter_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level arithmetic model.
module tb_hpm_counter_ctrl;

    localparam int EN  = 32;
    localparam int CN  = 8;
    localparam int CW  = 48;
    localparam int AW  = 5;
    localparam int INH = 2 * CN;
    localparam int OVF = 2 * CN + 1;
    localparam longint unsigned CMASK = (64'd1 << CW) - 64'd1;

    logic          clk;
    logic          rst;
    logic [EN-1:0] events;
    logic          csr_req_valid;
    logic          csr_req_ready;
    logic          csr_req_we;
    logic [AW-1:0] csr_req_addr;
    logic [63:0]   csr_req_wdata;
    logic          csr_resp_valid;
    logic          csr_resp_ready;
    logic [63:0]   csr_resp_rdata;
    logic          csr_resp_err;
    logic [CN-1:0] overflow;

    hpm_counter_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .events         (events),
        .csr_req_valid  (csr_req_valid),
        .csr_req_ready  (csr_req_ready),
        .csr_req_we     (csr_req_we),
        .csr_req_addr   (csr_req_addr),
        .csr_req_wdata  (csr_req_wdata),
        .csr_resp_valid (csr_resp_valid),
        .csr_resp_ready (csr_resp_ready),
        .csr_resp_rdata (csr_resp_rdata),
        .csr_resp_err   (csr_resp_err),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: architectural register values and the one-cycle-old event vector.
    longint unsigned m_cnt [CN];
    int unsigned     m_sel [CN];
    logic [CN-1:0]   m_inh, m_ovf;
    logic [EN-1:0]   m_evq;
    bit              m_busy;
    logic [63:0]     m_rdata;
    bit              m_err;

    function automatic void m_reset();
        for (int i = 0; i < CN; i++) begin
            m_cnt[i] = 0;
            m_sel[i] = 63;
        end
        m_inh   = '0;
        m_ovf   = '0;
        m_evq   = '0;
        m_busy  = 1'b0;
        m_rdata = '0;
        m_err   = 1'b0;
    endfunction

    function automatic void m_read(input int addr, output logic [63:0] d, output bit e);
        d = '0;
        e = 1'b0;
        if (addr < CN)            d = m_cnt[addr];
        else if (addr < 2 * CN)   d = 64'(m_sel[addr - CN]);
        else if (addr == INH)     d = 64'(m_inh);
        else if (addr == OVF)     d = 64'(m_ovf);
        else                      e = 1'b1;
    endfunction

    // Advance one clock: update the model from the inputs seen at the edge, then compare.
    task automatic step();
        bit hs;
        int a;
        @(posedge clk);
        if (!rst) begin
            m_reset();
        end else begin
            hs = !m_busy && csr_req_valid;
            a  = int'(csr_req_addr);
            if (hs) begin
                if (csr_req_we) begin
                    m_rdata = '0;
                    m_err   = (a > OVF);
                end else begin
                    m_read(a, m_rdata, m_err);
                end
            end
            if (hs && csr_req_we && a == OVF) m_ovf = m_ovf & ~csr_req_wdata[CN-1:0];
            for (int i = 0; i < CN; i++) begin
                bit counts;
                counts = 1'b0;
                if (m_sel[i] < EN && !m_inh[i]) counts = m_evq[m_sel[i]];
                if (hs && csr_req_we && a == i) begin
                    m_cnt[i] = csr_req_wdata & CMASK;
                end else if (counts) begin
                    if (m_cnt[i] == CMASK) begin
                        m_cnt[i] = 0;
                        m_ovf[i] = 1'b1;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
            for (int i = 0; i < CN; i++) begin
                if (hs && csr_req_we && a == CN + i) m_sel[i] = int'(csr_req_wdata[5:0]);
            end
            if (hs && csr_req_we && a == INH) m_inh = csr_req_wdata[CN-1:0];
            if (hs) m_busy = 1'b1;
            else if (m_busy && csr_resp_ready) m_busy = 1'b0;
            m_evq = events;
        end
        #1;
        check("req_ready", 64'(csr_req_ready), 64'(!m_busy));
        check("resp_valid", 64'(csr_resp_valid), 64'(m_busy));
        if (m_busy) begin
            check("resp_rdata", csr_resp_rdata, m_rdata);
            check("resp_err", 64'(csr_resp_err), 64'(m_err));
        end
        check("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    task automatic csr(input bit we, input int addr, input logic [63:0] wd,
                       output logic [63:0] rd, output logic er);
        csr_req_valid = 1'b1;
        csr_req_we    = we;
        csr_req_addr  = AW'(addr);
        csr_req_wdata = wd;
        step();
        csr_req_valid = 1'b0;
        rd = csr_resp_rdata;
        er = csr_resp_err;
        csr_resp_ready = 1'b1;
        step();
        csr_resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] rd;
        logic        er;
        int          a;
        logic [63:0] wd;

        rst            = 1'b0;
        events         = '0;
        csr_req_valid  = 1'b0;
        csr_req_we     = 1'b0;
        csr_req_addr   = '0;
        csr_req_wdata  = '0;
        csr_resp_ready = 1'b0;
        m_reset();

        // Reset values, observed without any clock edge.
        #2;
        check("rst_req_ready", 64'(csr_req_ready), 64'd1);
        check("rst_resp_valid", 64'(csr_resp_valid), 64'd0);
        check("rst_rdata", csr_resp_rdata, 64'd0);
        check("rst_err", 64'(csr_resp_err), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        #10 rst = 1'b1;
        step();

        // Reset contents of inhibit and a select.
        csr(1'b0, INH, 64'd0, rd, er);
        check("inh_reset_rd", rd, 64'd0);
        check("inh_reset_err", 64'(er), 64'd0);
        csr(1'b0, CN + 0, 64'd0, rd, er);
        check("sel0_reset_rd", rd, 64'd63);

        // Ten event pulses on line 5 into counter 0.
        csr(1'b1, CN + 0, 64'd5, rd, er);
        check("wr_rdata_zero", rd, 64'd0);
        events[5] = 1'b1;
        for (int k = 0; k < 10; k++) step();
        events = '0;
        step();
        step();
        csr(1'b0, 0, 64'd0, rd, er);
        check("cnt0_ten", rd, 64'd10);
        for (int i = 1; i < CN; i++) begin
            csr(1'b0, i, 64'd0, rd, er);
            check("cnt_other_zero", rd, 64'd0);
        end

        // Wrap of counter 1 and write-1-clear of its overflow flag.
        csr(1'b1, 1, CMASK - 64'd1, rd, er);
        csr(1'b1, CN + 1, 64'd3, rd, er);
        events[3] = 1'b1;
        for (int k = 0; k < 3; k++) step();
        events = '0;
        step();
        step();
        csr(1'b0, 1, 64'd0, rd, er);
        check("cnt1_wrapped", rd, 64'd1);
        check("ovf1_set", 64'(overflow[1]), 64'd1);
        csr(1'b1, OVF, 64'h2, rd, er);
        check("ovf1_cleared", 64'(overflow[1]), 64'd0);

        // Counter write collides with an increment: write wins.
        events[5] = 1'b1;
        step();
        step();
        csr(1'b1, 0, 64'd100, rd, er);
        events = '0;
        step();
        step();
        csr(1'b0, 0, 64'd0, rd, er);
        check("cnt0_write_wins", rd, 64'd102);

        // Response back-pressure: outputs hold, new request is ignored.
        csr_req_valid = 1'b1;
        csr_req_we    = 1'b0;
        csr_req_addr  = AW'(0);
        step();
        csr_req_we    = 1'b1;
        csr_req_addr  = AW'(INH);
        csr_req_wdata = 64'hFF;
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_req_ready", 64'(csr_req_ready), 64'd0);
            check("stall_rdata", csr_resp_rdata, 64'd102);
        end
        csr_req_valid  = 1'b0;
        csr_resp_ready = 1'b1;
        step();
        csr_resp_ready = 1'b0;
        csr(1'b0, INH, 64'd0, rd, er);
        check("stall_no_write", rd, 64'd0);
        csr(1'b0, 2 * CN + 5, 64'd0, rd, er);
        check("bad_idx_err", 64'(er), 64'd1);
        check("bad_idx_rdata", rd, 64'd0);

        // Randomized traffic against the model.
        for (int it = 0; it < 200; it++) begin
            int idle;
            idle = int'($urandom_range(0, 2));
            for (int k = 0; k < idle; k++) begin
                events = $urandom;
                step();
            end
            events = $urandom;
            a = int'($urandom_range(0, 23));
            if (a < CN)             wd = ($urandom_range(0, 1) == 1) ? CMASK - 64'($urandom_range(0, 5))
                                                                      : {$urandom, $urandom};
            else if (a < 2 * CN)    wd = 64'($urandom_range(0, 40));
            else if (a == INH)      wd = 64'($urandom_range(0, 255)) & 64'h3C;
            else                    wd = {$urandom, $urandom};
            csr(1'($urandom_range(0, 1)), a, wd, rd, er);
        end

        // Asynchronous reset while a response is pending.
        events = '0;
        csr(1'b1, INH, 64'hFF, rd, er);
        csr_req_valid = 1'b1;
        csr_req_we    = 1'b0;
        csr_req_addr  = AW'(INH);
        step();
        csr_req_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("arst_req_ready", 64'(csr_req_ready), 64'd1);
        check("arst_resp_valid", 64'(csr_resp_valid), 64'd0);
        check("arst_rdata", csr_resp_rdata, 64'd0);
        check("arst_err", 64'(csr_resp_err), 64'd0);
        check("arst_overflow", 64'(overflow), 64'd0);
        m_reset();
        step();
        #3 rst = 1'b1;
        step();
        check("post_rst_ready", 64'(csr_req_ready), 64'd1);
        csr(1'b0, INH, 64'd0, rd, er);
        check("post_rst_inh", rd, 64'd0);
        csr(1'b0, CN + 0, 64'd0, rd, er);
        check("post_rst_sel0", rd, 64'd63);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
